// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NUM_RD combinational read ports,
// and a post-reset clear engine that zeroes every entry before ready is raised.
module regfile_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [WIDTH-1:0]         wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [WIDTH-1:0]         wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]  rdata,
    output logic                     ready,
    output logic                     wr_collide
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              collide_q, collide_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              wr0_en, wr1_en;

    always_comb begin
        wr0_en = (state_q == ST_READY) && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
        wr1_en = (state_q == ST_READY) && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        collide_d = wr0_en && wr1_en && (waddr0 == waddr1);
        if (state_q == ST_CLEAR) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '1) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            idx_q     <= '0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            collide_q <= collide_d;
        end
    end

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_CLEAR) begin
                mem_q[idx_q] <= '0;
            end else begin
                if (wr0_en) mem_q[waddr0] <= wdata0;
                if (wr1_en) mem_q[waddr1] <= wdata1;
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_lane(input logic [ADDR_W-1:0] a);
        if (state_q != ST_READY)                          return '0;
        if ((ZERO_REG != 0) && (a == '0))                 return '0;
        if ((BYPASS != 0) && we1 && (waddr1 == a))        return wdata1;
        if ((BYPASS != 0) && we0 && (waddr0 == a))        return wdata0;
        return mem_q[a];
    endfunction

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rdata[i*WIDTH +: WIDTH] = read_lane(raddr[i*ADDR_W +: ADDR_W]);
        end
    end

    assign ready      = (state_q == ST_READY);
    assign wr_collide = collide_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass and four-read-port instances
// share the write ports and reset; expectations are hand-computed constants.
module tb_regfile_mp;

    logic         clk;
    logic         rst_n;
    logic         we0, we1;
    logic [4:0]   waddr0, waddr1;
    logic [31:0]  wdata0, wdata1;
    logic [9:0]   raddr;
    logic [19:0]  raddr4;
    logic [63:0]  rdata, rdata_nb;
    logic [127:0] rdata4;
    logic         ready, ready_nb, ready4;
    logic         coll, coll_nb, coll4;

    int n_chk;
    int n_pass;
    int cyc;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .ready(ready), .wr_collide(coll)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nb), .ready(ready_nb), .wr_collide(coll_nb)
    );

    regfile_mp #(.NUM_RD(4)) u_r4 (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr4), .rdata(rdata4), .ready(ready4), .wr_collide(coll4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    // Counts edges from reset release until ready rises, checking clear-phase outputs.
    task automatic run_clear(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 100) begin
            check("clear_lane0", rdata[31:0], 32'h0);
            check("clear_lane0_nb", rdata_nb[31:0], 32'h0);
            check("clear_collide", coll, 1'b0);
            tick();
            cycles++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        idle_writes();
        raddr  = {5'd6, 5'd7};
        raddr4 = '0;

        repeat (3) tick();
        check("rst_ready", ready, 1'b0);
        check("rst_collide", coll, 1'b0);
        check("rst_lane0_a7", rdata[31:0], 32'h0);

        // Release reset while hammering both write ports at address 4.
        rst_n = 1'b1;
        raddr = {5'd7, 5'd4};
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hCAFE0001;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hCAFE0002;
        #1;
        run_clear(cyc);
        idle_writes();
        check("clear_len", cyc, 32);
        check("ready_nb", ready_nb, 1'b1);
        #1;
        check("post_clear_a4", rdata[31:0], 32'h0);
        check("post_clear_a7", rdata[63:32], 32'h0);
        check("post_clear_collide", coll, 1'b0);

        // Basic write + bypass on port 0.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        raddr = {5'd6, 5'd5};
        #1;
        check("byp_a5", rdata[31:0], 32'hDEADBEEF);
        check("nobyp_a5", rdata_nb[31:0], 32'h0);
        tick();
        idle_writes();
        #1;
        check("wr_a5", rdata[31:0], 32'hDEADBEEF);
        check("wr_a6", rdata[63:32], 32'h0);
        check("nobyp_wr_a5", rdata_nb[31:0], 32'hDEADBEEF);

        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h12345678;
        raddr = {5'd9, 5'd5};
        #1;
        check("byp_lane1_a9", rdata[63:32], 32'h12345678);
        check("nobyp_lane1_a9", rdata_nb[63:32], 32'h0);
        tick();
        idle_writes();
        #1;
        check("wr_a9", rdata[63:32], 32'h12345678);

        // Collision at address 3: port 1 wins in storage and in bypass.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h5555FFFF;
        raddr = {5'd9, 5'd3};
        #1;
        check("byp_prio_a3", rdata[31:0], 32'h5555FFFF);
        tick();
        idle_writes();
        #1;
        check("coll_a3_rf", rdata[31:0], 32'h5555FFFF);
        check("coll_a3_nb_rf", rdata_nb[31:0], 32'h5555FFFF);
        check("coll_a3_flag", coll, 1'b1);
        tick();
        check("coll_a3_pulse_end", coll, 1'b0);

        // Collision at the zero register is dropped entirely.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h5555FFFF;
        raddr = {5'd3, 5'd0};
        #1;
        check("byp_zero", rdata[31:0], 32'h0);
        tick();
        idle_writes();
        #1;
        check("coll_a0_rf", rdata[31:0], 32'h0);
        check("coll_a0_flag", coll, 1'b0);

        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        tick();
        idle_writes();
        #1;
        check("zero_w1", rdata[31:0], 32'h0);

        // Distinct addresses on both ports: no collision.
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h10;
        we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h11;
        tick();
        idle_writes();
        raddr = {5'd11, 5'd10};
        #1;
        check("dual_a10", rdata[31:0], 32'h10);
        check("dual_a11", rdata[63:32], 32'h11);
        check("dual_collide", coll, 1'b0);

        // Four read lanes.
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h2;
        tick();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h4;
        tick();
        idle_writes();
        raddr4 = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        check("r4_lanes", rdata4, {32'h4, 32'h3, 32'h2, 32'h1});
        raddr4 = {5'd5, 5'd5, 5'd5, 5'd5};
        #1;
        check("r4_shared", rdata4, {4{32'hDEADBEEF}});

        // Reset mid-clear restarts the index.
        rst_n = 1'b0;
        tick();
        check("rst2_ready", ready, 1'b0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("midclear_ready", ready, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        raddr = {5'd9, 5'd5};
        #1;
        run_clear(cyc);
        check("midclear_len", cyc, 32);
        check("midclear_r4_ready", ready4, 1'b1);
        check("reclr_a5", rdata[31:0], 32'h0);
        check("reclr_a9", rdata[63:32], 32'h0);
        check("reclr_r4", rdata4, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
